// File: rtl/bitstream_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bitstream_decoder
//  Purpose  : Counts the ones of a stochastic bitstream over fixed windows of
//             2^WIDTH qualified cycles and presents each window's count
//             through a valid/ready output register (latest result wins).
//  Ports    : clk      - clock, all state changes on its rising edge
//             rst      - synchronous active-high reset
//             en       - qualifies x; only en=1 cycles advance the window
//             x        - bitstream bit
//             sync     - abort the current window, restart at cycle 0
//             count    - ones in the last completed window (0..2^WIDTH)
//             valid    - count holds an untaken result
//             ready    - consumer accepts count when valid & ready
//             overrun  - sticky flag, an untaken result was overwritten
//                        (only present with BITSTREAM_DECODER_OVERRUN_EN)
//  Options  : `define BITSTREAM_DECODER_OVERRUN_EN adds the overrun port.
//  Revision : 1.0 - initial release
// ============================================================================
module bitstream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             sync,
    output logic [WIDTH:0]   count,
    output logic             valid,
    input  logic             ready
`ifdef BITSTREAM_DECODER_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_cycle;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH:0]     w_acc_plus_x;
    logic               w_last;
    logic               w_complete;

    assign w_acc_plus_x = r_acc + (WIDTH+1)'(x);
    assign w_last       = (r_cycle == {WIDTH{1'b1}});
    // A sync on the final cycle wins: the window is discarded, not completed.
    assign w_complete   = en && w_last && !sync;

    // ------------------------------------------------------------------
    // Window counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            r_cycle <= '0;
            r_acc   <= '0;
        end else if (en) begin
            if (w_last) begin
                // Next window starts immediately on the following cycle.
                r_cycle <= '0;
                r_acc   <= '0;
            end else begin
                r_cycle <= r_cycle + 1'b1;
                r_acc   <= w_acc_plus_x;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register: loaded on every completion, regardless of state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (w_complete) begin
            count <= w_acc_plus_x;
        end
    end

    // ------------------------------------------------------------------
    // Output state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                // Completion keeps FULL even when the old result is accepted
                // at the same edge: the new result replaces it seamlessly.
                if (!w_complete && ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    assign valid = (r_state == S_FULL);

`ifdef BITSTREAM_DECODER_OVERRUN_EN
    // Overwrite of an untaken result: completion while FULL and not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (w_complete && (r_state == S_FULL) && !ready) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitstream_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitstream_decoder
//  Purpose  : Directed self-checking bench for bitstream_decoder (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitstream_decoder;

    localparam int c_WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               en;
    logic               x;
    logic               sync;
    logic               ready;
    logic [c_WIDTH:0]   count;
    logic               valid;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
    logic               overrun;
`endif

    int n_total;
    int n_bad;

    bitstream_decoder #(.WIDTH(c_WIDTH)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .x       (x),
        .sync    (sync),
        .count   (count),
        .valid   (valid),
        .ready   (ready)
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit after it.
    task automatic cyc(input logic e, input logic xx, input logic s, input logic r);
        en = e; x = xx; sync = s; ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n, input logic e, input logic xx, input logic r);
        for (int i = 0; i < n; i++) cyc(e, xx, 1'b0, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; en = 1'b0; x = 1'b0; sync = 1'b0; ready = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_valid", 32'(valid), 0);
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        check_eq("rst_overrun", 32'(overrun), 0);
`endif

        // All ones window, ready=1: valid for exactly one cycle
        run_n(255, 1'b1, 1'b1, 1'b1);
        check_eq("ones_pre_valid", 32'(valid), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("ones_valid", 32'(valid), 1);
        check_eq("ones_count", 32'(count), 256);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ones_valid_drop", 32'(valid), 0);

        // Alternating window -> 128, then a paused window lasting 266 cycles
        for (int i = 0; i < 256; i++) cyc(1'b1, (i % 2 == 0), 1'b0, 1'b1);
        check_eq("alt_valid", 32'(valid), 1);
        check_eq("alt_count", 32'(count), 128);
        run_n(100, 1'b1, 1'b1, 1'b1);
        run_n(10,  1'b0, 1'b0, 1'b1);
        run_n(155, 1'b1, 1'b1, 1'b1);
        check_eq("pause_pre_valid", 32'(valid), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("pause_valid", 32'(valid), 1);
        check_eq("pause_count", 32'(count), 256);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // ready=0 across two windows: 100 then 40 ones, latest wins
        run_n(100, 1'b1, 1'b1, 1'b0);
        run_n(156, 1'b1, 1'b0, 1'b0);
        check_eq("ovw_first_count", 32'(count), 100);
        run_n(40, 1'b1, 1'b1, 1'b0);
        run_n(100, 1'b1, 1'b0, 1'b0);
        check_eq("ovw_hold_count", 32'(count), 100);
        check_eq("ovw_hold_valid", 32'(valid), 1);
        run_n(116, 1'b1, 1'b0, 1'b0);
        check_eq("ovw_second_count", 32'(count), 40);
        check_eq("ovw_second_valid", 32'(valid), 1);
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        check_eq("ovw_overrun", 32'(overrun), 1);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovw_accept_valid", 32'(valid), 0);
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        check_eq("ovw_overrun_sticky", 32'(overrun), 1);
`endif

        // Accept on the exact completion edge of the second window
        do_reset();
        run_n(10, 1'b1, 1'b1, 1'b0);
        run_n(246, 1'b1, 1'b0, 1'b0);
        check_eq("acc_first_count", 32'(count), 10);
        run_n(20, 1'b1, 1'b1, 1'b0);
        run_n(235, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("acc_valid", 32'(valid), 1);
        check_eq("acc_count", 32'(count), 20);
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        check_eq("acc_overrun", 32'(overrun), 0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("acc_drain_valid", 32'(valid), 0);

        // sync after 100 ones, then an all-zero window
        run_n(100, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        run_n(255, 1'b1, 1'b0, 1'b1);
        check_eq("sync_pre_valid", 32'(valid), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("sync_valid", 32'(valid), 1);
        check_eq("sync_count", 32'(count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // sync coinciding with completion produces no result
        run_n(255, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("syncprio_valid", 32'(valid), 0);
        run_n(256, 1'b1, 1'b1, 1'b1);
        check_eq("syncprio_restart_valid", 32'(valid), 1);
        check_eq("syncprio_restart_count", 32'(count), 256);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // rst mid-window with a result pending
        run_n(256, 1'b1, 1'b1, 1'b0);
        check_eq("rstmid_pre_valid", 32'(valid), 1);
        run_n(200, 1'b1, 1'b1, 1'b0);
        do_reset();
        check_eq("rstmid_count", 32'(count), 0);
        check_eq("rstmid_valid", 32'(valid), 0);
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        check_eq("rstmid_overrun", 32'(overrun), 0);
`endif
        run_n(255, 1'b1, 1'b1, 1'b0);
        check_eq("rstmid_post_pre_valid", 32'(valid), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rstmid_post_valid", 32'(valid), 1);
        check_eq("rstmid_post_count", 32'(count), 255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitstream_decoder.md
BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: window length is 2^WIDTH bitstream cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port en  input  1  qualifies x; a window cycle is consumed only when en=1.
REQ-005 SHALL have port x  input  1  stochastic bitstream bit; 1 counts as a one.
REQ-006 SHALL have port sync  input  1  abort current window and restart counting at cycle 0.
REQ-007 SHALL have port count  output  WIDTH+1  number of ones in the last completed window, range 0..2^WIDTH.
REQ-008 SHALL have port valid  output  1  count holds an untaken result.
REQ-009 SHALL have port ready  input  1  consumer accepts count when valid=1 and ready=1 at a rising edge.
REQ-010 SHALL have port overrun  output  1  sticky: an untaken result was overwritten (present only when the macro is defined).

Function
REQ-011 SHALL keep a cycle counter (WIDTH bits) and a ones accumulator (WIDTH+1 bits); both hold when en=0.
REQ-012 SHALL, per cycle with en=1, add x to the accumulator and increment the cycle counter.
REQ-013 SHALL complete a window on the en=1 cycle where the cycle counter equals 2^WIDTH-1.
REQ-014 SHALL load count with accumulator+x on the edge ending the completing cycle; valid=1 from the next cycle (latency 1).
REQ-015 SHALL, on completion, clear the accumulator and wrap the cycle counter to 0 at the same edge; the next window starts with no gap cycle.
REQ-016 SHALL represent an all-ones window as 2^WIDTH (256 for WIDTH=8) without wrap; an all-zeros window as 0.
REQ-017 SHALL implement output states EMPTY (valid=0) and FULL (valid=1).
REQ-018 SHALL move EMPTY->FULL on completion.
REQ-019 SHALL move FULL->EMPTY on valid&ready without completion.
REQ-020 SHALL stay FULL on completion, with the new count loaded.
REQ-021 SHALL hold count stable while FULL and not accepted.
REQ-022 SHALL, on completion while FULL with ready=0, overwrite count with the newest result (latest wins).
REQ-023 SHALL treat simultaneous accept and completion as a transfer of the old count and a load of the new one; valid stays 1 and no overrun occurs.
REQ-024 SHALL, on sync=1, clear the accumulator and cycle counter at that edge, discarding that cycle's x; it SHALL not affect count, valid or overrun.
REQ-025 SHALL give sync priority over completion when both occur in one cycle: no result is produced.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set count=0, valid=0, overrun=0, accumulator=0 and cycle counter=0, overriding all other inputs.
REQ-027 SHALL discard a partially accumulated window when rst is asserted mid-window; the first window after rst release starts at cycle 0.

Configuration
REQ-028 SHALL use macro BITSTREAM_DECODER_OVERRUN_EN to control the overrun port.
REQ-029 SHALL, when BITSTREAM_DECODER_OVERRUN_EN is defined, provide port overrun, set on a REQ-022 overwrite and cleared only by rst.
REQ-030 SHALL, when BITSTREAM_DECODER_OVERRUN_EN is undefined, omit port overrun and its logic; overwrite is silent and all other behaviour is identical.

Verification
REQ-031 SHALL cover: WIDTH=8, en=1, ready=1, x=1 for 256 cycles -> count=256, valid high exactly 1 cycle, starting 1 cycle after the last bit.
REQ-032 SHALL cover: x=1 on every 2nd cycle for 256 cycles, then en=0 for 10 cycles mid-next-window -> count=128; the paused window resumes and ends 266 cycles after its start.
REQ-033 SHALL cover: ready=0 across two complete windows (100 ones, then 40 ones) -> count=40, valid=1, overrun=1 (macro defined) or no overrun port (macro undefined).
REQ-034 SHALL cover: ready asserted on the exact completion edge of the second window -> first count transferred, valid stays 1, second count presented, overrun=0.
REQ-035 SHALL cover: sync after 100 cycles of x=1, then 256 cycles of x=0 -> count=0; the aborted window never produces a result.
REQ-036 SHALL cover: rst at cycle 200 of a window with valid=1 -> next cycle count=0, valid=0, overrun=0; the next result appears 256 en-cycles after rst release.
